// File: rtl/ex_stage.sv
// ex_stage: execute stage (forwarding, ALU, branch/jump resolution, iterative RV32M unit); EX_FAST_MUL_EN selects a single-step multiplier.
// Latency: ALU/branch combinational; MD ops 34 cycles in E (divide-by-zero 2, MUL* 2 with EX_FAST_MUL_EN).
// Backpressure: md_stall holds F/D while the MD unit owns the stage; the held instruction retires in DONE.
module ex_stage #(
   parameter int XLEN      = 32,
   parameter int MD_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            regwritee,
   input  logic            memwritee,
   input  logic            jumpe,
   input  logic            branche,
   input  logic            alusrce,
   input  logic            alusrce_u,
   input  logic [1:0]      resultsrce,
   input  logic [3:0]      alucontrole,
   input  logic            mde,
   input  logic [XLEN-1:0] rd1e,
   input  logic [XLEN-1:0] rd2e,
   input  logic [XLEN-1:0] pce,
   input  logic [XLEN-1:0] extimme,
   input  logic [XLEN-1:0] pcplus4e,
   input  logic [4:0]      rde,
   input  logic [6:0]      opcodee,
   input  logic [2:0]      funct3e,
   input  logic [1:0]      forwardae,
   input  logic [1:0]      forwardbe,
   input  logic [XLEN-1:0] aluresultm,
   input  logic [XLEN-1:0] resultw,
   output logic [XLEN-1:0] aluresultx,
   output logic [XLEN-1:0] writedatax,
   output logic [XLEN-1:0] pcplus4x,
   output logic            regwritex,
   output logic            memwritex,
   output logic [1:0]      resultsrcx,
   output logic [4:0]      rdx,
   output logic [XLEN-1:0] pctargete,
   output logic            pcsrce,
   output logic            md_stall
);
   localparam int CW = $clog2(MD_CYCLES);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] op_mag, acc_hi, acc_lo;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic            neg_q, neg_r;

   logic [XLEN-1:0]   fa, fb, src_a, src_b, alu_res, md_res;
   logic [XLEN-1:0]   mag_a, mag_b, quo, rem, div_diff;
   logic [XLEN:0]     mul_sum, div_sh;
   logic [2*XLEN-1:0] prod, prod_s;
   logic              taken, md_start, sgn_a, sgn_b, neg_a, neg_b, div_ge;

   always_comb begin
      case (forwardae)
         2'b01:   fa = resultw;
         2'b10:   fa = aluresultm;
         default: fa = rd1e;
      endcase
      case (forwardbe)
         2'b01:   fb = resultw;
         2'b10:   fb = aluresultm;
         default: fb = rd2e;
      endcase
   end

   assign src_a = alusrce_u ? pce : fa;
   assign src_b = alusrce ? extimme : fb;

   always_comb begin
      case (alucontrole)
         4'b0000: alu_res = src_a + src_b;
         4'b0001: alu_res = src_a - src_b;
         4'b0010: alu_res = src_a & src_b;
         4'b0011: alu_res = src_a | src_b;
         4'b0100: alu_res = src_a ^ src_b;
         4'b0101: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         4'b0110: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
         4'b0111: alu_res = src_a << src_b[4:0];
         4'b1000: alu_res = src_a >> src_b[4:0];
         4'b1001: alu_res = $unsigned($signed(src_a) >>> src_b[4:0]);
         4'b1010: alu_res = src_b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      case (funct3e)
         3'b000:  taken = (fa == fb);
         3'b001:  taken = (fa != fb);
         3'b100:  taken = ($signed(fa) < $signed(fb));
         3'b101:  taken = ($signed(fa) >= $signed(fb));
         3'b110:  taken = (fa < fb);
         3'b111:  taken = (fa >= fb);
         default: taken = 1'b0;
      endcase
   end

   assign pctargete = (opcodee == 7'b1100111) ? ((fa + extimme) & {{(XLEN-1){1'b1}}, 1'b0})
                                               : (pce + extimme);
   assign pcsrce    = (jumpe | (branche & taken)) & (state == IDLE);
   assign md_start  = (state == IDLE) & mde;
   assign md_stall  = md_start | (state == BUSY);

   // Operand signedness: MULH/MULHSU/DIV/REM treat rs1 as signed; MULH/DIV/REM also rs2.
   assign sgn_a = (funct3e == 3'b001) | (funct3e == 3'b010) | (funct3e == 3'b100) | (funct3e == 3'b110);
   assign sgn_b = (funct3e == 3'b001) | (funct3e == 3'b100) | (funct3e == 3'b110);
   assign neg_a = sgn_a & fa[XLEN-1];
   assign neg_b = sgn_b & fb[XLEN-1];
   assign mag_a = neg_a ? -fa : fa;
   assign mag_b = neg_b ? -fb : fb;

   // Multiply: acc_hi:acc_lo shifts right, multiplier consumed from acc_lo[0].
   // Divide: acc_lo holds dividend bits shifting into the remainder acc_hi, quotient bits enter at LSB.
   assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_mag} : {(XLEN+1){1'b0}});
   assign div_sh   = {acc_hi, acc_lo[XLEN-1]};
   assign div_ge   = (div_sh >= {1'b0, op_mag});
   assign div_diff = div_sh[XLEN-1:0] - op_mag;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_mag <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         f3_q   <= '0;
         rd_q   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (mde) begin
               f3_q <= funct3e;
               rd_q <= rde;
               cnt  <= '0;
               if (funct3e[2]) begin
                  op_mag <= mag_b;
                  neg_r  <= neg_a;
                  if (fb == '0) begin
                     acc_hi <= mag_a;
                     acc_lo <= '1;
                     neg_q  <= 1'b0;
                     state  <= DONE;
                  end else begin
                     acc_hi <= '0;
                     acc_lo <= mag_a;
                     neg_q  <= neg_a ^ neg_b;
                     state  <= BUSY;
                  end
               end else begin
                  op_mag <= mag_a;
                  acc_hi <= '0;
                  acc_lo <= mag_b;
                  neg_q  <= neg_a ^ neg_b;
                  neg_r  <= 1'b0;
`ifdef EX_FAST_MUL_EN
                  state  <= DONE;
`else
                  state  <= BUSY;
`endif
               end
            end
            BUSY: begin
               if (f3_q[2]) begin
                  acc_hi <= div_ge ? div_diff : div_sh[XLEN-1:0];
                  acc_lo <= {acc_lo[XLEN-2:0], div_ge};
               end else begin
                  {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
               end
               if (cnt == CW'(MD_CYCLES-1)) state <= DONE;
               else                         cnt   <= cnt + 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      prod = {acc_hi, acc_lo};
`ifdef EX_FAST_MUL_EN
      if (!f3_q[2]) prod = {{XLEN{1'b0}}, op_mag} * {{XLEN{1'b0}}, acc_lo};
`endif
      prod_s = neg_q ? -prod : prod;
      quo    = neg_q ? -acc_lo : acc_lo;
      rem    = neg_r ? -acc_hi : acc_hi;
      case (f3_q)
         3'b000:                 md_res = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: md_res = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         md_res = quo;
         default:                md_res = rem;
      endcase
   end

   always_comb begin
      aluresultx = alu_res;
      writedatax = fb;
      pcplus4x   = pcplus4e;
      regwritex  = regwritee;
      memwritex  = memwritee;
      resultsrcx = resultsrce;
      rdx        = rde;
      if (state == DONE) begin
         aluresultx = md_res;
         writedatax = '0;
         pcplus4x   = '0;
         regwritex  = 1'b1;
         memwritex  = 1'b0;
         resultsrcx = 2'b00;
         rdx        = rd_q;
      end else if (md_stall) begin
         regwritex  = 1'b0;
         memwritex  = 1'b0;
         resultsrcx = 2'b00;
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage with a queue-based scoreboard of expected EX/MEM results.
// Latency: ALU steps checked same cycle; MD ops checked in their DONE cycle with latency counted.
// Backpressure: bench mimics the hazard unit by clearing ID/EX inputs while md_stall is high.
`timescale 1ns/1ps
module tb_ex_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        regwritee, memwritee, jumpe, branche, alusrce, alusrce_u, mde;
   logic [1:0]  resultsrce, forwardae, forwardbe;
   logic [3:0]  alucontrole;
   logic [31:0] rd1e, rd2e, pce, extimme, pcplus4e, aluresultm, resultw;
   logic [4:0]  rde;
   logic [6:0]  opcodee;
   logic [2:0]  funct3e;
   logic [31:0] aluresultx, writedatax, pcplus4x, pctargete;
   logic        regwritex, memwritex, pcsrce, md_stall;
   logic [1:0]  resultsrcx;
   logic [4:0]  rdx;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst(rst),
      .regwritee(regwritee), .memwritee(memwritee), .jumpe(jumpe), .branche(branche),
      .alusrce(alusrce), .alusrce_u(alusrce_u), .resultsrce(resultsrce), .alucontrole(alucontrole),
      .mde(mde), .rd1e(rd1e), .rd2e(rd2e), .pce(pce), .extimme(extimme), .pcplus4e(pcplus4e),
      .rde(rde), .opcodee(opcodee), .funct3e(funct3e), .forwardae(forwardae), .forwardbe(forwardbe),
      .aluresultm(aluresultm), .resultw(resultw),
      .aluresultx(aluresultx), .writedatax(writedatax), .pcplus4x(pcplus4x),
      .regwritex(regwritex), .memwritex(memwritex), .resultsrcx(resultsrcx), .rdx(rdx),
      .pctargete(pctargete), .pcsrce(pcsrce), .md_stall(md_stall)
   );

`ifdef EX_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic        regw;
      logic        pcsrc;
      logic [31:0] tgt;
      logic        chk_tgt;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      regwritee = 0; memwritee = 0; jumpe = 0; branche = 0; alusrce = 0; alusrce_u = 0; mde = 0;
      resultsrce = 0; forwardae = 0; forwardbe = 0; alucontrole = 0;
      rd1e = 0; rd2e = 0; pce = 0; extimme = 0; pcplus4e = 0; aluresultm = 0; resultw = 0;
      rde = 0; opcodee = 0; funct3e = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic push(input string tag, input logic [31:0] res, input logic regw,
                       input logic pcsrc, input logic [31:0] tgt, input logic chk_tgt);
      exp_t e;
      e.tag = tag; e.res = res; e.regw = regw; e.pcsrc = pcsrc; e.tgt = tgt; e.chk_tgt = chk_tgt;
      sb.push_back(e);
   endtask

   task automatic compare_now();
      exp_t e;
      if (sb.size() == 0) begin
         n_tests++; n_fail++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         chk32($sformatf("%s.alu", e.tag), aluresultx, e.res);
         chk1($sformatf("%s.regw", e.tag), regwritex, e.regw);
         chk1($sformatf("%s.pcsrc", e.tag), pcsrce, e.pcsrc);
         if (e.chk_tgt) chk32($sformatf("%s.tgt", e.tag), pctargete, e.tgt);
      end
   endtask

   task automatic compare_e();
      @(negedge clk);
      compare_now();
   endtask

   task automatic md_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res, input int lat);
      int cyc, stall_cyc;
      bit bad_regw, done;
      step();
      mde = 1; funct3e = f3; rd1e = a; rd2e = b; rde = rd;
      regwritee = 1; memwritee = 1; resultsrce = 2'b01;
      push(tag, res, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc = 1; stall_cyc = 0; bad_regw = 0; done = 0;
      @(negedge clk);
      chk1($sformatf("%s.start_stall", tag), md_stall, 1'b1);
      chk1($sformatf("%s.start_regw", tag), regwritex, 1'b0);
      chk1($sformatf("%s.start_memw", tag), memwritex, 1'b0);
      if (md_stall) stall_cyc++;
      while (!done && cyc < 100) begin
         step();
         @(negedge clk);
         cyc++;
         if (md_stall) begin
            stall_cyc++;
            if (regwritex) bad_regw = 1;
         end else begin
            done = 1;
         end
      end
      chk32($sformatf("%s.latency", tag), cyc, lat);
      chk32($sformatf("%s.stall_cycles", tag), stall_cyc, lat - 1);
      chk1($sformatf("%s.regw_while_stalled", tag), bad_regw, 1'b0);
      compare_now();
      chk32($sformatf("%s.rd", tag), {27'b0, rdx}, {27'b0, rd});
      step();
      @(negedge clk);
      chk1($sformatf("%s.after_regw", tag), regwritex, 1'b0);
      chk1($sformatf("%s.after_stall", tag), md_stall, 1'b0);
   endtask

   initial begin
      bit leak;
      rst = 1;
      idle_inputs();
      @(posedge clk); #1;
      @(negedge clk);
      chk1("reset.md_stall", md_stall, 1'b0);
      chk1("reset.regw", regwritex, 1'b0);
      chk1("reset.memw", memwritex, 1'b0);
      chk1("reset.pcsrc", pcsrce, 1'b0);
      @(posedge clk); #1;
      rst = 0;

      // Pass-through ALU and forwarding
      step(); alucontrole = 4'b0000; forwardae = 2'b10; aluresultm = 5; rd2e = 7; regwritee = 1;
      memwritee = 1; resultsrce = 2'b10; rde = 5'd11; pcplus4e = 32'h44;
      push("add_fwd_m", 32'd12, 1'b1, 1'b0, 32'h0, 1'b0);
      compare_e();
      chk1("add_fwd_m.memw", memwritex, 1'b1);
      chk32("add_fwd_m.rd", {27'b0, rdx}, 32'd11);
      chk32("add_fwd_m.pcplus4", pcplus4x, 32'h44);
      chk32("add_fwd_m.resultsrc", {30'b0, resultsrcx}, 32'd2);

      step(); alucontrole = 4'b0001; rd1e = 10; forwardbe = 2'b01; resultw = 3;
      push("sub_fwd_w", 32'd7, 1'b0, 1'b0, 32'h0, 1'b0);
      compare_e();
      chk32("sub_fwd_w.writedata", writedatax, 32'd3);

      step(); forwardae = 2'b11; rd1e = 9; aluresultm = 100; alusrce = 1; extimme = 1;
      push("fwd_11", 32'd10, 1'b0, 1'b0, 32'h0, 1'b0);
      compare_e();

      step(); alusrce_u = 1; pce = 32'h100; alusrce = 1; extimme = 32'h20;
      push("auipc", 32'h120, 1'b0, 1'b0, 32'h120, 1'b1);
      compare_e();

      step(); alucontrole = 4'b1001; rd1e = 32'h8000_0000; alusrce = 1; extimme = 4;
      push("sra", 32'hF800_0000, 1'b0, 1'b0, 32'h4, 1'b1);
      compare_e();

      step(); alucontrole = 4'b1000; rd1e = 32'h8000_0000; alusrce = 1; extimme = 4;
      push("srl", 32'h0800_0000, 1'b0, 1'b0, 32'h4, 1'b0);
      compare_e();

      step(); alucontrole = 4'b0111; rd1e = 32'h0000_0003; alusrce = 1; extimme = 32'h24;
      push("sll_amt5", 32'h0000_0030, 1'b0, 1'b0, 32'h0, 1'b0);
      compare_e();

      step(); alucontrole = 4'b0101; rd1e = 32'hFFFF_FFFF; rd2e = 1;
      push("slt", 32'd1, 1'b0, 1'b0, 32'h0, 1'b0);
      compare_e();

      step(); alucontrole = 4'b0110; rd1e = 32'hFFFF_FFFF; rd2e = 1;
      push("sltu", 32'd0, 1'b0, 1'b0, 32'h0, 1'b0);
      compare_e();

      step(); alucontrole = 4'b0100; rd1e = 32'hF0F0_F0F0; rd2e = 32'hFF00_FF00;
      push("xor", 32'h0FF0_0FF0, 1'b0, 1'b0, 32'h0, 1'b0);
      compare_e();

      step(); alucontrole = 4'b1010; rd1e = 32'h1234; alusrce = 1; extimme = 32'hABCD;
      push("passb", 32'hABCD, 1'b0, 1'b0, 32'h0, 1'b0);
      compare_e();

      step(); alucontrole = 4'b1111; rd1e = 32'h1234; rd2e = 32'h5678;
      push("bad_op", 32'd0, 1'b0, 1'b0, 32'h0, 1'b0);
      compare_e();

      // Branches and jumps
      step(); alucontrole = 4'b0001; rd1e = 32'hFFFF_FFFF; rd2e = 1; branche = 1; funct3e = 3'b100;
      opcodee = 7'b1100011; pce = 32'h100; extimme = 32'h20;
      push("blt", 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h120, 1'b1);
      compare_e();

      step(); alucontrole = 4'b0001; rd1e = 32'hFFFF_FFFF; rd2e = 1; branche = 1; funct3e = 3'b110;
      opcodee = 7'b1100011; pce = 32'h100; extimme = 32'h20;
      push("bltu", 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h120, 1'b1);
      compare_e();

      step(); alucontrole = 4'b0001; rd1e = 5; rd2e = 6; branche = 1; funct3e = 3'b000;
      opcodee = 7'b1100011; pce = 32'h300; extimme = 32'h8;
      push("beq_nt", 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h308, 1'b1);
      compare_e();

      step(); alucontrole = 4'b0001; rd1e = 5; rd2e = 6; branche = 1; funct3e = 3'b001;
      opcodee = 7'b1100011; pce = 32'h300; extimme = 32'h8;
      push("bne", 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h308, 1'b1);
      compare_e();

      step(); alucontrole = 4'b0001; rd1e = 5; rd2e = 5; branche = 1; funct3e = 3'b010;
      opcodee = 7'b1100011;
      push("bad_f3", 32'd0, 1'b0, 1'b0, 32'h0, 1'b1);
      compare_e();

      step(); opcodee = 7'b1100111; jumpe = 1; rd1e = 32'h1001; extimme = 4; alusrce = 1; regwritee = 1;
      push("jalr", 32'h1005, 1'b1, 1'b1, 32'h1004, 1'b1);
      compare_e();

      step(); opcodee = 7'b1101111; jumpe = 1; pce = 32'h200; extimme = 32'h40;
      push("jal", 32'h0, 1'b0, 1'b1, 32'h240, 1'b1);
      compare_e();

      // RV32M
      md_op("mulh",   3'b001, 32'hFFFF_FFFE, 32'd3,         5'd7,  32'hFFFF_FFFF, MUL_LAT);
      md_op("mul",    3'b000, 32'hFFFF_FFFD, 32'd7,         5'd8,  32'hFFFF_FFEB, MUL_LAT);
      md_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, MUL_LAT);
      md_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF, MUL_LAT);
      md_op("div0",   3'b100, 32'd7,         32'd0,         5'd11, 32'hFFFF_FFFF, 2);
      md_op("rem0",   3'b110, 32'd7,         32'd0,         5'd12, 32'd7,         2);
      md_op("div0n",  3'b100, 32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFFF, 2);
      md_op("rem0n",  3'b110, 32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFF9, 2);
      md_op("div_ovf",3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 34);
      md_op("rem_neg",3'b110, 32'hFFFF_FFF9, 32'd2,         5'd16, 32'hFFFF_FFFF, 34);
      md_op("div_neg",3'b100, 32'hFFFF_FFF9, 32'd2,         5'd17, 32'hFFFF_FFFD, 34);
      md_op("divu",   3'b101, 32'd100,       32'd7,         5'd18, 32'd14,        34);
      md_op("remu",   3'b111, 32'd100,       32'd7,         5'd19, 32'd2,         34);

      // Reset in the middle of a divide (counter == 10)
      step(); mde = 1; funct3e = 3'b101; rd1e = 32'd1000; rd2e = 32'd3; rde = 5'd20; regwritee = 1;
      step();
      repeat (10) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk1("rst_busy.md_stall", md_stall, 1'b0);
      chk1("rst_busy.regw", regwritex, 1'b0);
      leak = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (regwritex || md_stall) leak = 1;
      end
      chk1("rst_busy.no_result", leak, 1'b0);
      chk32("scoreboard_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
